pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register for the five-stage MIPS core. It generalises the fixed IF/ID latch to any payload width and adds a valid/ready handshake, a synchronous flush that inserts a bubble, and a saturating stall counter. An optional two-entry skid buffer breaks the combinational ready path. It is instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the payload bundled per stage.

---
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready, flush-to-bubble, stall counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered In_Ready.
module pipe_stage_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] RST_VAL    = '0,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Data_Out,
  output logic [1:0]        Count,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hd_q, hd_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              push, pop;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] sk_q, sk_d;
`endif

  // State encoding equals the occupancy, so Count is a plain register output
  assign Count     = state_q;
  assign Out_Valid = (state_q != EMPTY);
  assign Data_Out  = hd_q;
  assign Stall_Cnt = stall_q;

`ifdef PIPE_SKID_EN
  assign In_Ready = (state_q != TWO);
`else
  assign In_Ready = !Out_Valid || Out_Ready;
`endif

  assign push = In_Valid && In_Ready;
  assign pop  = Out_Valid && Out_Ready;

  // Next occupancy and head/skid contents; flush overrides with a bubble
  always_comb begin
    state_d = state_q;
    hd_d    = hd_q;
`ifdef PIPE_SKID_EN
    sk_d    = sk_q;
`endif
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          hd_d    = Data_In;
        end
      end
      ONE: begin
        if (push && pop) begin
          hd_d = Data_In;
        end else if (pop) begin
          state_d = EMPTY;
`ifdef PIPE_SKID_EN
        end else if (push) begin
          state_d = TWO;
          sk_d    = Data_In;
`endif
        end
      end
`ifdef PIPE_SKID_EN
      TWO: begin
        if (pop) begin
          state_d = ONE;
          hd_d    = sk_q;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (Flush) begin
      state_d = EMPTY;
      hd_d    = BUBBLE_VAL;
    end
  end

  // Saturating count of cycles where a valid head is held back
  always_comb begin
    stall_d = stall_q;
    if (Out_Valid && !Out_Ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State, head and stall registers; reset outranks flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      hd_q    <= RST_VAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      hd_q    <= hd_d;
      stall_q <= stall_d;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid register holds the entry accepted while the head was stalled
  always_ff @(posedge CLK) begin
    if (RST) begin
      sk_q <= RST_VAL;
    end else begin
      sk_q <= sk_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: queue-based reference model plus directed
// scenarios for reset, streaming, backpressure, flush and saturation.
module tb_pipe_stage_reg;

  localparam int             W   = 32;
  localparam logic [W-1:0]   RV  = 32'hDEAD_BEEF;
  localparam logic [W-1:0]   BV  = 32'h0BAD_F00D;
  localparam int             SMAX = 65535;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] data_in, data_out;
  logic [1:0]   count;
  logic [15:0]  stall_cnt;

  logic         rst2, fl2, iv2, ir2, ov2, or2;
  logic [7:0]   di2, do2;
  logic [1:0]   cnt2;
  logic [2:0]   st2;

  pipe_stage_reg #(
    .DATA_W(W), .RST_VAL(RV), .BUBBLE_VAL(BV), .CNT_W(16)
  ) dut (
    .CLK(clk), .RST(rst), .Flush(flush),
    .In_Valid(in_valid), .In_Ready(in_ready), .Data_In(data_in),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Data_Out(data_out),
    .Count(count), .Stall_Cnt(stall_cnt)
  );

  pipe_stage_reg #(
    .DATA_W(8), .RST_VAL(8'h01), .BUBBLE_VAL(8'h00), .CNT_W(3)
  ) dut2 (
    .CLK(clk), .RST(rst2), .Flush(fl2),
    .In_Valid(iv2), .In_Ready(ir2), .Data_In(di2),
    .Out_Valid(ov2), .Out_Ready(or2), .Data_Out(do2),
    .Count(cnt2), .Stall_Cnt(st2)
  );

  logic [W-1:0] q[$];
  logic [W-1:0] shown;
  int           stall;
  int           errs = 0;
  int           checks = 0;

  function automatic logic m_ready();
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  task automatic cycle();
    logic push, pop;
    push = in_valid && m_ready();
    pop  = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      shown = RV;
      stall = 0;
    end else begin
      if (q.size() > 0 && !out_ready && stall < SMAX) stall++;
      if (flush) begin
        q.delete();
        shown = BV;
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(data_in);
        if (q.size() > 0) shown = q[0];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 1; in_valid = 1; out_ready = 0; data_in = 32'h1234;
    cycle();
    cycle();
    rst = 0; flush = 0; in_valid = 0;
    #1;
    checks++;
    if (data_out !== RV) begin
      errs++; $display("FAIL reset_dout got=%h exp=%h", data_out, RV);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    checks++;
    if (count !== 2'd0 || stall_cnt !== 16'd0) begin
      errs++; $display("FAIL reset_cnt got c=%0d s=%0d exp 0 0", count, stall_cnt);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; data_in = W'(i);
      cycle();
      checks++;
      if (data_out !== W'(i) || out_valid !== 1'b1 || count !== 2'd1) begin
        errs++;
        $display("FAIL stream_%0d got d=%0d v=%b c=%0d exp d=%0d v=1 c=1",
                 i, data_out, out_valid, count, i);
      end
    end
    in_valid = 0;
    cycle();
    checks++;
    if (data_out !== 32'd4 || out_valid !== 1'b0 || count !== 2'd0) begin
      errs++;
      $display("FAIL stream_drain got d=%0d v=%b c=%0d exp d=4 v=0 c=0",
               data_out, out_valid, count);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] src[$];
    logic [W-1:0] got[$];
    logic         acc;
    int           s0;
    src = '{32'd5, 32'd6, 32'd7};
    s0 = stall;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = (src.size() > 0);
      data_in  = (src.size() > 0) ? src[0] : '0;
      #1;
      acc = in_valid && m_ready();
      cycle();
      if (acc) void'(src.pop_front());
    end
    checks++;
    if (count !== 2'(CAP) || in_ready !== 1'b0 || data_out !== 32'd5) begin
      errs++;
      $display("FAIL bp_hold got c=%0d r=%b d=%0d exp c=%0d r=0 d=5",
               count, in_ready, data_out, CAP);
    end
    checks++;
    if (32'(stall_cnt) !== 32'(s0 + 3)) begin
      errs++; $display("FAIL bp_stall got=%0d exp=%0d", stall_cnt, s0 + 3);
    end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (src.size() > 0);
      data_in  = (src.size() > 0) ? src[0] : '0;
      #1;
      acc = in_valid && m_ready();
      if (out_valid) got.push_back(data_out);
      cycle();
      if (acc) void'(src.pop_front());
    end
    checks++;
    if (got.size() != 3) begin
      errs++; $display("FAIL bp_order_len got=%0d exp=3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== W'(k + 5)) begin
          errs++; $display("FAIL bp_order_%0d got=%0d exp=%0d", k, got[k], k + 5);
        end
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    data_in = 32'd8; cycle();
    data_in = 32'd9; cycle();
    flush = 1; data_in = 32'd10; cycle();
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || data_out !== BV || count !== 2'd0) begin
      errs++;
      $display("FAIL flush got v=%b d=%h c=%0d exp v=0 d=%h c=0",
               out_valid, data_out, count, BV);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (data_out === 32'd10 || out_valid !== 1'b0) begin
        errs++; $display("FAIL flush_leak got d=%0d v=%b exp d!=10 v=0", data_out, out_valid);
      end
    end
    in_valid = 1; data_in = 32'd11; cycle();
    in_valid = 0;
    checks++;
    if (data_out !== 32'd11 || out_valid !== 1'b1) begin
      errs++; $display("FAIL flush_resume got d=%0d v=%b exp d=11 v=1", data_out, out_valid);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      data_in   = $urandom;
      flush     = $urandom_range(0, 15) == 0;
      rst       = $urandom_range(0, 63) == 0;
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errs++; $display("FAIL rnd_ready_%0d got=%b exp=%b", i, in_ready, m_ready());
      end
      cycle();
      checks++;
      if (data_out !== shown || out_valid !== (q.size() > 0) ||
          count !== 2'(q.size()) || 32'(stall_cnt) !== 32'(stall)) begin
        errs++;
        $display("FAIL rnd_%0d got d=%h v=%b c=%0d s=%0d exp d=%h v=%b c=%0d s=%0d",
                 i, data_out, out_valid, count, stall_cnt,
                 shown, q.size() > 0, q.size(), stall);
      end
    end
    rst = 0; flush = 0; in_valid = 0;
  endtask

  task automatic test_rst_vs_flush();
    rst2 = 1; fl2 = 0; iv2 = 0; or2 = 0; di2 = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rst2 = 0; iv2 = 1; di2 = 8'h55;
    @(posedge clk); #1;
    iv2 = 0;
    checks++;
    if (do2 !== 8'h55 || ov2 !== 1'b1) begin
      errs++; $display("FAIL rvf_load got d=%h v=%b exp d=55 v=1", do2, ov2);
    end
    rst2 = 1; fl2 = 1;
    @(posedge clk); #1;
    rst2 = 0; fl2 = 0;
    checks++;
    if (do2 !== 8'h01 || ov2 !== 1'b0 || cnt2 !== 2'd0 || st2 !== 3'd0) begin
      errs++;
      $display("FAIL rst_vs_flush got d=%h v=%b c=%0d s=%0d exp d=01 v=0 c=0 s=0",
               do2, ov2, cnt2, st2);
    end
  endtask

  task automatic test_saturation();
    int e;
    iv2 = 1; di2 = 8'hA5; or2 = 0;
    @(posedge clk); #1;
    iv2 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      e = (k < 7) ? k : 7;
      checks++;
      if (32'(st2) !== 32'(e)) begin
        errs++; $display("FAIL sat_%0d got=%0d exp=%0d", k, st2, e);
      end
    end
    checks++;
    if (do2 !== 8'hA5 || ov2 !== 1'b1) begin
      errs++; $display("FAIL sat_hold got d=%h v=%b exp d=a5 v=1", do2, ov2);
    end
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; data_in = '0;
    rst2 = 1; fl2 = 0; iv2 = 0; or2 = 0; di2 = '0;
    shown = RV; stall = 0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    test_rst_vs_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
